exp2_iter: RTL

Iterative fixed-point base-2 antilog unit: takes a log2 value in unsigned Q5.6 and returns 2^x in unsigned fixed point. It is the inverse of the team's iterative log2 block and accepts that block's output format directly, so a value can round-trip log2 → processing → exp2.
- Fractional part: bit-serial multiply by constants 2^(2^-k).
- Integer part: a final left shift.
- Handshake: one start/done pair per operation, fixed latency.

---
 rtl/exp2_iter.sv | 118 +++++++++++
 1 files changed

// File: rtl/exp2_iter.sv
// exp2_iter: iterative fixed-point antilog, y = 2^x with x unsigned Q(IW).(FW), y unsigned Q(OW).(OFW)
// Ports: clk, rst_n (async active-low), start/x request, busy/done handshake, y result, ovf saturation flag.
// Option: define EXP2_ROUND_EN to round to nearest in each multiply and in the final shift (default truncates).
module exp2_iter #(
  parameter int IW  = 5,
  parameter int FW  = 6,
  parameter int OW  = 32,
  parameter int OFW = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [IW+FW-1:0]    x,
  output logic                busy,
  output logic                done,
  output logic [OW+OFW-1:0]   y,
  output logic                ovf
);
  localparam int KW = $clog2(FW + 2);
  localparam int SW = 17 + OW + OFW;
  localparam int DN = OFW < 15 ? 15 - OFW : 0;
  localparam int UP = OFW > 15 ? OFW - 15 : 0;
`ifdef EXP2_ROUND_EN
  localparam logic [31:0]   RM = 32'd16384;
  localparam logic [SW-1:0] RY = DN > 0 ? SW'(1) << (DN > 0 ? DN - 1 : 0) : '0;
`else
  localparam logic [31:0]   RM = '0;
  localparam logic [SW-1:0] RY = '0;
`endif
  typedef enum logic [1:0] {IDLE, FRAC, SHIFT, DONE} state_t;
  state_t                state_q, state_d;
  logic [15:0]           m_q, m_d;
  logic [KW-1:0]         k_q, k_d;
  logic [IW-1:0]         int_q, int_d;
  logic [FW-1:0]         frac_q, frac_d;
  logic [OW+OFW-1:0]     y_q, y_d;
  logic                  ovf_q, ovf_d;
  logic [31:0]           prod;
  logic [SW-1:0]         res;
  logic                  sat;
  // round(2^(2^-k) * 2^15); entries past k=16 round to exactly 1.0
  function automatic logic [15:0] rom(input logic [KW-1:0] k);
    case (int'(k))
      1:  rom = 16'd46341;
      2:  rom = 16'd38968;
      3:  rom = 16'd35734;
      4:  rom = 16'd34219;
      5:  rom = 16'd33486;
      6:  rom = 16'd33125;
      7:  rom = 16'd32946;
      8:  rom = 16'd32857;
      9:  rom = 16'd32812;
      10: rom = 16'd32790;
      11: rom = 16'd32779;
      12: rom = 16'd32774;
      13: rom = 16'd32771;
      14: rom = 16'd32769;
      15: rom = 16'd32769;
      default: rom = 16'h8000;
    endcase
  endfunction
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    k_d     = k_q;
    int_d   = int_q;
    frac_d  = frac_q;
    y_d     = y_q;
    ovf_d   = ovf_q;
    prod    = 32'(m_q) * 32'(rom(k_q)) + RM;
    // mantissa scaled by the integer part, then aligned to OFW fraction bits
    res     = (((SW'(m_q) << int_q) + RY) >> DN) << UP;
    sat     = int'(int_q) >= OW || |res[SW-1:OW+OFW];
    case (state_q)
      IDLE: if (start) begin
        state_d = FRAC;
        int_d   = x[IW+FW-1:FW];
        frac_d  = x[FW-1:0];
        m_d     = 16'h8000;
        k_d     = KW'(1);
      end
      FRAC: begin
        m_d     = frac_q[FW-1] ? 16'(prod >> 15) : m_q;
        frac_d  = frac_q << 1;
        k_d     = k_q + 1'b1;
        state_d = k_q == KW'(FW) ? SHIFT : FRAC;
      end
      SHIFT: begin
        y_d     = sat ? '1 : res[OW+OFW-1:0];
        ovf_d   = sat;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= 16'h8000;
      k_q     <= '0;
      int_q   <= '0;
      frac_q  <= '0;
      y_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      k_q     <= k_d;
      int_q   <= int_d;
      frac_q  <= frac_d;
      y_q     <= y_d;
      ovf_q   <= ovf_d;
    end
  assign busy = state_q == FRAC || state_q == SHIFT;
  assign done = state_q == DONE;
  assign y    = y_q;
  assign ovf  = ovf_q;
endmodule
